// File: rtl/tone_period_meter.sv
// tone_period_meter: measures the half-period of a square-wave input, reported in tone-generator compare encoding
module tone_period_meter #(
    parameter int               WIDTH   = 22,
    parameter logic [WIDTH-1:0] MAX_CNT = WIDTH'(22'h3F_FFFF),
    parameter int               TOL     = 1,
    parameter int               LOCK_N  = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             tone_i,
    output logic [WIDTH-1:0] cmp_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             lost_o
);
    localparam int               SW     = $clog2(LOCK_N + 1);
    localparam logic [SW-1:0]    LOCK_V = SW'(LOCK_N);
    localparam logic [WIDTH:0]   TOL_V  = (WIDTH + 1)'(TOL);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync_q, hist_q, edge_w;
    logic [WIDTH-1:0] cnt_q, cnt_d, cmp_d;
    logic [SW-1:0]    stab_q, stab_d, stab_inc, stab_new;
    logic             valid_d, locked_d, lost_d;
    logic [WIDTH:0]   diff;

    assign edge_w = sync_q ^ hist_q;
    assign diff   = (cnt_q >= cmp_o) ? {1'b0, cnt_q} - {1'b0, cmp_o} : {1'b0, cmp_o} - {1'b0, cnt_q};

    // Synchronizer and history flop run regardless of enable so re-enabling never sees a stale edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) {sync1_q, sync_q, hist_q} <= 3'b000;
        else          {sync1_q, sync_q, hist_q} <= {tone_i, sync1_q, sync_q};
    end

    // Next-state, counter and output decode; an edge always beats a coincident timeout
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmp_d    = cmp_o;
        stab_d   = stab_q;
        locked_d = locked_o;
        valid_d  = 1'b0;
        lost_d   = 1'b0;
        stab_inc = (stab_q >= LOCK_V) ? LOCK_V : stab_q + SW'(1);
        stab_new = (diff <= TOL_V) ? stab_inc : SW'(1);
        if (!en_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            stab_d   = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = edge_w ? ARM : IDLE;
                end
                ARM, MEASURE: begin
                    if (edge_w) begin
                        cnt_d    = '0;
                        cmp_d    = cnt_q;
                        valid_d  = 1'b1;
                        stab_d   = (state_q == ARM) ? SW'(1) : stab_new;
                        locked_d = (stab_d == LOCK_V);
                        state_d  = MEASURE;
                    end else if (cnt_q == MAX_CNT) begin
                        cnt_d    = '0;
                        stab_d   = '0;
                        locked_d = 1'b0;
                        lost_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            stab_q   <= '0;
            cmp_o    <= '0;
            valid_o  <= 1'b0;
            locked_o <= 1'b0;
            lost_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stab_q   <= stab_d;
            cmp_o    <= cmp_d;
            valid_o  <= valid_d;
            locked_o <= locked_d;
            lost_o   <= lost_d;
        end
    end
endmodule

// File: tb/tb_tone_period_meter.sv
// tb_tone_period_meter: directed checks of period measurement, lock, timeout, enable and async reset
module tb_tone_period_meter;
    logic        clk_i = 1'b0;
    logic        rst_n_i, en_i, tone_i;
    logic [21:0] cmp_o;
    logic        valid_o, locked_o, lost_o;
    int          checks = 0;
    int          errors = 0;
    int          nv, nl, lost_at;
    logic [31:0] lc;

    tone_period_meter #(.WIDTH(22), .MAX_CNT(22'd50), .TOL(1), .LOCK_N(3)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .tone_i(tone_i),
        .cmp_o(cmp_o), .valid_o(valid_o), .locked_o(locked_o), .lost_o(lost_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
        nv += int'(valid_o);
        nl += int'(lost_o);
        if (valid_o) lc = 32'(cmp_o);
    endtask

    // Toggle the input, hold it n cycles, check the measurement produced by this toggle's edge
    task automatic hp(input int n, input int ev, input int ec, input logic el, input string tag);
        nv = 0;
        nl = 0;
        lc = '1;
        tone_i = ~tone_i;
        repeat (n) cyc();
        chk({tag, ".valid"}, 32'(nv), 32'(ev));
        if (ev != 0) chk({tag, ".cmp"}, lc, 32'(ec));
        chk({tag, ".locked"}, 32'(locked_o), 32'(el));
        chk({tag, ".lost"}, 32'(nl), 32'd0);
    endtask

    initial begin
        rst_n_i = 1'b0;
        en_i    = 1'b1;
        tone_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst.cmp", 32'(cmp_o), 32'd0);
        chk("rst.valid", 32'(valid_o), 32'd0);
        chk("rst.locked", 32'(locked_o), 32'd0);
        chk("rst.lost", 32'(lost_o), 32'd0);
        rst_n_i = 1'b1;
        hp(10, 0, 0, 1'b0, "t1.w1");
        hp(10, 1, 9, 1'b0, "t1.w2");
        hp(10, 1, 9, 1'b0, "t1.w3");
        hp(10, 1, 9, 1'b1, "t1.w4");
        hp(10, 1, 9, 1'b1, "t1.w5");
        en_i = 1'b0;
        cyc();
        chk("en.unlock", 32'(locked_o), 32'd0);
        hp(10, 0, 0, 1'b0, "en.low1");
        hp(10, 0, 0, 1'b0, "en.low2");
        en_i = 1'b1;
        hp(10, 0, 0, 1'b0, "en.arm");
        hp(10, 1, 9, 1'b0, "en.first");
        hp(11, 1, 9, 1'b0, "alt.a");
        hp(10, 1, 10, 1'b1, "alt.b");
        hp(11, 1, 9, 1'b1, "alt.c");
        hp(14, 1, 10, 1'b1, "alt.d");
        hp(10, 1, 13, 1'b0, "jump");
        hp(10, 1, 9, 1'b0, "relock.a");
        hp(10, 1, 9, 1'b0, "relock.b");
        hp(10, 1, 9, 1'b1, "relock.c");
        nv = 0;
        nl = 0;
        lost_at = 0;
        for (int j = 1; j <= 70; j++) begin
            cyc();
            if (lost_o && lost_at == 0) lost_at = j;
        end
        chk("to.count", 32'(nl), 32'd1);
        chk("to.when", 32'(lost_at), 32'd44);
        chk("to.valid", 32'(nv), 32'd0);
        chk("to.locked", 32'(locked_o), 32'd0);
        chk("to.cmp", 32'(cmp_o), 32'd9);
        hp(20, 0, 0, 1'b0, "to.rearm");
        hp(51, 1, 19, 1'b0, "max.pre");
        hp(10, 1, 50, 1'b0, "max.edge");
        hp(10, 1, 9, 1'b0, "pre.a");
        hp(10, 1, 9, 1'b0, "pre.b");
        hp(10, 1, 9, 1'b1, "pre.c");
        #2;
        rst_n_i = 1'b0;
        tone_i  = 1'b0;
        #1;
        chk("arst.cmp", 32'(cmp_o), 32'd0);
        chk("arst.valid", 32'(valid_o), 32'd0);
        chk("arst.locked", 32'(locked_o), 32'd0);
        chk("arst.lost", 32'(lost_o), 32'd0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        hp(10, 0, 0, 1'b0, "post.arm");
        hp(10, 1, 9, 1'b0, "post.a");
        hp(10, 1, 9, 1'b0, "post.b");
        hp(10, 1, 9, 1'b1, "post.c");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
